// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM state type
// and the size/alignment fault check used when an access is accepted.
package load_store_unit_pkg;

   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   // Size field shared by ls_store_type and ls_load_type[1:0]; 2'b11 is illegal.
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam int LD_SIGNED_BIT = 2;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_REQ  = 2'b01,
      LSU_WAIT = 2'b10,
      LSU_DONE = 2'b11
   } lsu_state_e;

   function automatic logic access_fault(input logic       is_write,
                                         input logic [2:0] ld_type,
                                         input logic [1:0] st_type,
                                         input logic [1:0] off);
      logic [1:0] size;
      logic       bad;
      size = is_write ? st_type : ld_type[1:0];
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = off[0];
         SIZE_W:  bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: store byte-enable generation and lane replication,
// load field extraction with sign/zero extension.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]        st_type,
   input  logic [1:0]        st_off,
   input  logic [DATA_W-1:0] st_data,
   input  logic [2:0]        ld_type,
   input  logic [1:0]        ld_off,
   input  logic [DATA_W-1:0] rdata,
   output logic [BE_W-1:0]   st_be,
   output logic [DATA_W-1:0] st_wdata,
   output logic [DATA_W-1:0] ld_result
);

   logic [DATA_W-1:0] field;
   logic              ld_signed;

   always_comb begin
      st_be    = '0;
      st_wdata = '0;
      case (st_type)
         SIZE_B: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         SIZE_H: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         SIZE_W: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
         default: begin
            st_be    = '0;
            st_wdata = '0;
         end
      endcase
   end

   // The addressed byte lane is shifted down to bit 0 before truncation.
   always_comb begin
      ld_signed = ld_type[LD_SIGNED_BIT];
      field     = rdata >> {ld_off, 3'b000};
      case (ld_type[1:0])
         SIZE_B:  ld_result = {{24{ld_signed & field[7]}}, field[7:0]};
         SIZE_H:  ld_result = {{16{ld_signed & field[15]}}, field[15:0]};
         default: ld_result = field;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: accepts one memory instruction from the core, issues a
// single valid/ready request, waits for load data and reports completion or a fault.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ls_valid,
   input  logic              ls_write,
   input  logic [2:0]        ls_load_type,
   input  logic [1:0]        ls_store_type,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_stall,
   output logic              ls_done,
   output logic              ls_fault,
   output logic [31:0]       ld_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state
);

   // Handshake: a request transfers on a cycle with mem_req_valid & mem_req_ready; once
   // raised, valid and payload stay unchanged until that cycle. Each accepted load gets
   // exactly one mem_rsp_valid pulse, no earlier than the cycle after acceptance.

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        ld_type_q, ld_type_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              fault_q, fault_d;
   logic [31:0]       ld_data_q, ld_data_d;

   logic [3:0]        st_be;
   logic [31:0]       st_wdata;
   logic [31:0]       ld_result;
   logic              fault_now;

   assign fault_now = access_fault(ls_write, ls_load_type, ls_store_type, ls_addr[1:0]);

   // Store steering uses the live inputs; load extraction uses the captured type/offset.
   lsu_align u_align (
      .st_type   (ls_store_type),
      .st_off    (ls_addr[1:0]),
      .st_data   (ls_wdata),
      .ld_type   (ld_type_q),
      .ld_off    (off_q),
      .rdata     (mem_rdata),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_result (ld_result)
   );

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      ld_type_d = ld_type_q;
      off_d     = off_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      fault_d   = fault_q;
      ld_data_d = ld_data_q;
      case (state_q)
         LSU_IDLE: begin
            if (ls_valid) begin
               we_d      = ls_write;
               ld_type_d = ls_load_type;
               off_d     = ls_addr[1:0];
               addr_d    = {ls_addr[ADDR_W-1:2], 2'b00};
               be_d      = ls_write ? st_be : 4'b1111;
               wdata_d   = ls_write ? st_wdata : 32'h0;
               fault_d   = fault_now;
               state_d   = fault_now ? LSU_DONE : LSU_REQ;
            end
         end
         LSU_REQ: begin
            if (mem_req_ready) begin
               state_d = we_q ? LSU_DONE : LSU_WAIT;
            end
         end
         LSU_WAIT: begin
            if (mem_rsp_valid) begin
               ld_data_d = ld_result;
               state_d   = LSU_DONE;
            end
         end
         LSU_DONE: begin
            state_d = LSU_IDLE;
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= LSU_IDLE;
         we_q      <= 1'b0;
         ld_type_q <= '0;
         off_q     <= '0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         fault_q   <= 1'b0;
         ld_data_q <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         ld_type_q <= ld_type_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         fault_q   <= fault_d;
         ld_data_q <= ld_data_d;
      end
   end

   assign ls_done       = (state_q == LSU_DONE);
   assign ls_fault      = ls_done & fault_q;
   assign ls_stall      = ls_valid & ~ls_done;
   assign ld_data       = ld_data_q;
   assign mem_req_valid = (state_q == LSU_REQ);
   assign mem_we        = we_q;
   assign mem_be        = be_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of directed accesses, randomized accesses checked
// against a byte-lane model, and a reset-during-WAIT sequence.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ls_valid, ls_write;
   logic [2:0]  ls_load_type;
   logic [1:0]  ls_store_type;
   logic [31:0] ls_addr, ls_wdata;
   logic        ls_stall, ls_done, ls_fault;
   logic [31:0] ld_data;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [47:0] exp_q[$];

   typedef struct {
      logic        wr;
      logic [2:0]  lt;
      logic [1:0]  st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          rdy_wait;
      int          rsp_wait;
      logic        e_fault;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [31:0] e_ld;
      int          e_done;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ls_valid      (ls_valid),
      .ls_write      (ls_write),
      .ls_load_type  (ls_load_type),
      .ls_store_type (ls_store_type),
      .ls_addr       (ls_addr),
      .ls_wdata      (ls_wdata),
      .ls_stall      (ls_stall),
      .ls_done       (ls_done),
      .ls_fault      (ls_fault),
      .ld_data       (ld_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_we        (mem_we),
      .mem_be        (mem_be),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata),
      .dbg_state     (dbg_state)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic wr, input logic [2:0] lt, input logic [1:0] st,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int rw, input int rs,
                               input logic ef, input logic [3:0] eb, input logic [31:0] ew,
                               input logic [31:0] el, input int ed);
      vec_t v;
      v.wr = wr; v.lt = lt; v.st = st; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.rdy_wait = rw; v.rsp_wait = rs; v.e_fault = ef; v.e_be = eb;
      v.e_addr = {addr[31:2], 2'b00}; v.e_wdata = ew; v.e_ld = el; v.e_done = ed;
      return v;
   endfunction

   // Independent byte-lane model for the randomized accesses.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      logic [1:0] size;
      int n, off;
      r = v;
      size = v.wr ? v.st : v.lt[1:0];
      off = int'(v.addr[1:0]);
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      r.e_fault = (size == 2'd3) || (size == 2'd1 && v.addr[0]) ||
                  (size == 2'd2 && v.addr[1:0] != 2'b00);
      r.e_addr = v.addr & 32'hFFFF_FFFC;
      r.e_be = 4'b0;
      r.e_wdata = 32'h0;
      r.e_ld = 32'h0;
      for (int b = 0; b < 4; b++) begin
         r.e_be[b] = (b >= off) && (b < off + n);
         r.e_wdata[8*b +: 8] = v.wdata[8*(b % n) +: 8];
      end
      if (!r.e_fault && !v.wr) begin
         for (int i = 0; i < n; i++) r.e_ld[8*i +: 8] = v.rdata[8*(off+i) +: 8];
         if (v.lt[2] && r.e_ld[8*n-1]) begin
            for (int i = n; i < 4; i++) r.e_ld[8*i +: 8] = 8'hFF;
         end
      end
      if (r.e_fault) r.e_done = 1;
      else if (v.wr) r.e_done = 2 + v.rdy_wait;
      else r.e_done = 2 + v.rdy_wait + v.rsp_wait;
      return r;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int req_cnt, acc_cyc, done_cyc;
      logic stall_bad, dup_req, unstable, have_p;
      logic [68:0] p_payload, c_payload;
      logic [47:0] e;
      req_cnt = 0; acc_cyc = -1; done_cyc = -1;
      stall_bad = 1'b0; dup_req = 1'b0; unstable = 1'b0; have_p = 1'b0;
      p_payload = '0;
      exp_q.push_back({7'd0, v.e_fault, 8'(v.e_done), v.e_ld});
      for (int cyc = 0; cyc < 60; cyc++) begin
         step();
         ls_valid = 1'b1; ls_write = v.wr; ls_load_type = v.lt; ls_store_type = v.st;
         ls_addr = v.addr; ls_wdata = v.wdata;
         mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
         if (mem_req_valid) begin
            if (acc_cyc >= 0) dup_req = 1'b1;
            c_payload = {mem_we, mem_be, mem_addr, mem_wdata};
            if (have_p && c_payload !== p_payload) unstable = 1'b1;
            p_payload = c_payload; have_p = 1'b1;
            if (req_cnt >= v.rdy_wait && acc_cyc < 0) begin
               mem_req_ready = 1'b1;
               acc_cyc = cyc;
               chk({tag, " mem_addr"}, mem_addr, v.e_addr);
               chk({tag, " mem_we"}, {31'd0, mem_we}, {31'd0, v.wr});
               if (v.wr) begin
                  chk({tag, " mem_be"}, {28'd0, mem_be}, {28'd0, v.e_be});
                  chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
               end
            end
            req_cnt++;
         end
         if (!v.wr && acc_cyc >= 0 && cyc == acc_cyc + v.rsp_wait) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = v.rdata;
         end
         #1;
         if (ls_done) begin
            done_cyc = cyc;
            break;
         end
         if (!ls_stall) stall_bad = 1'b1;
      end
      e = exp_q.pop_front();
      chk({tag, " completed"}, {31'd0, done_cyc >= 0}, 32'd1);
      chk({tag, " done_cycle"}, done_cyc, {24'd0, e[39:32]});
      chk({tag, " ls_fault"}, {31'd0, ls_fault}, {31'd0, e[40]});
      chk({tag, " stall_on_done"}, {31'd0, ls_stall}, 32'd0);
      if (!v.wr && !e[40]) chk({tag, " ld_data"}, ld_data, e[31:0]);
      chk({tag, " req_count"}, req_cnt, v.e_fault ? 0 : v.rdy_wait + 1);
      chk({tag, " stall_gaps"}, {31'd0, stall_bad}, 32'd0);
      chk({tag, " payload_stable"}, {31'd0, unstable}, 32'd0);
      chk({tag, " dup_request"}, {31'd0, dup_req}, 32'd0);
      step();
      ls_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      #1;
      chk({tag, " idle_after"}, {30'd0, mem_req_valid, ls_done}, 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " ls_done"}, {31'd0, ls_done}, 32'd0);
      chk({tag, " ls_fault"}, {31'd0, ls_fault}, 32'd0);
      chk({tag, " ls_stall"}, {31'd0, ls_stall}, 32'd0);
      chk({tag, " mem_req_valid"}, {31'd0, mem_req_valid}, 32'd0);
      chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, " mem_be"}, {28'd0, mem_be}, 32'd0);
      chk({tag, " mem_addr"}, mem_addr, 32'd0);
      chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, " ld_data"}, ld_data, 32'd0);
      chk({tag, " state"}, {30'd0, dbg_state}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rv;
      logic stray;
      //          wr    lt      st     addr          wdata         rdata        rw rs  flt be       wdata_al      ld          done
      vecs[0]  = mk(1'b1, 3'b000, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0,        2);
      vecs[1]  = mk(1'b1, 3'b000, 2'b00, 32'h103, 32'h000000A5, 32'h0,        0, 1, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0,        2);
      vecs[2]  = mk(1'b0, 3'b100, 2'b00, 32'h102, 32'h0,        32'h0080FF00, 0, 3, 1'b0, 4'b1111, 32'h0,        32'hFFFFFF80, 5);
      vecs[3]  = mk(1'b0, 3'b000, 2'b00, 32'h102, 32'h0,        32'h0080FF00, 0, 3, 1'b0, 4'b1111, 32'h0,        32'h00000080, 5);
      vecs[4]  = mk(1'b0, 3'b101, 2'b00, 32'h101, 32'h0,        32'h0,        0, 1, 1'b1, 4'b0000, 32'h0,        32'h0,        1);
      vecs[5]  = mk(1'b1, 3'b000, 2'b10, 32'h102, 32'h12345678, 32'h0,        0, 1, 1'b1, 4'b0000, 32'h0,        32'h0,        1);
      vecs[6]  = mk(1'b0, 3'b010, 2'b00, 32'h200, 32'h0,        32'h12345678, 4, 1, 1'b0, 4'b1111, 32'h0,        32'h12345678, 7);
      vecs[7]  = mk(1'b1, 3'b000, 2'b01, 32'h102, 32'h0000BEEF, 32'h0,        0, 1, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0,        2);
      vecs[8]  = mk(1'b0, 3'b101, 2'b00, 32'h102, 32'h0,        32'h80010000, 0, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFF8001, 3);
      vecs[9]  = mk(1'b0, 3'b011, 2'b00, 32'h000, 32'h0,        32'h0,        0, 1, 1'b1, 4'b0000, 32'h0,        32'h0,        1);
      vecs[10] = mk(1'b1, 3'b000, 2'b11, 32'h040, 32'h11223344, 32'h0,        0, 1, 1'b1, 4'b0000, 32'h0,        32'h0,        1);
      vecs[11] = mk(1'b0, 3'b110, 2'b00, 32'h304, 32'h0,        32'hCAFEF00D, 1, 2, 1'b0, 4'b1111, 32'h0,        32'hCAFEF00D, 5);
      vecs[12] = mk(1'b0, 3'b100, 2'b00, 32'h101, 32'h0,        32'h00007F00, 0, 1, 1'b0, 4'b1111, 32'h0,        32'h0000007F, 3);

      rst_n = 1'b0; ls_valid = 1'b0; ls_write = 1'b0; ls_load_type = 3'b0; ls_store_type = 2'b0;
      ls_addr = 32'h0; ls_wdata = 32'h0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      mem_rdata = 32'h0;
      repeat (3) step();
      rst_n = 1'b1;
      #1;
      chk_all_zero("reset");

      for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         rv.wr = 1'($urandom_range(0, 1));
         rv.st = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         rv.lt = ($urandom_range(0, 9) == 0) ? 3'b011 :
                 {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         rv.addr = $urandom & 32'h0000_0FFF;
         if ($urandom_range(0, 3) != 0) begin
            if ((rv.wr ? rv.st : rv.lt[1:0]) == 2'b10) rv.addr[1:0] = 2'b00;
            if ((rv.wr ? rv.st : rv.lt[1:0]) == 2'b01) rv.addr[0] = 1'b0;
         end
         rv.wdata = $urandom;
         rv.rdata = $urandom;
         rv.rdy_wait = $urandom_range(0, 2);
         rv.rsp_wait = $urandom_range(1, 3);
         rv = model(rv);
         run_op(rv, $sformatf("rnd%0d", i));
      end

      // Reset while waiting for a load response, then a stray response.
      step();
      ls_valid = 1'b1; ls_write = 1'b0; ls_load_type = 3'b010; ls_addr = 32'h100;
      step();
      mem_req_ready = mem_req_valid;
      step();
      mem_req_ready = 1'b0; rst_n = 1'b0; ls_valid = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk_all_zero("rst_wait");
      mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
      stray = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         mem_rsp_valid = 1'b0;
         #1;
         if (ls_done || ls_fault || mem_req_valid || ld_data != 32'h0 || dbg_state != 2'b00)
            stray = 1'b1;
      end
      chk("stray_rsp_ignored", {31'd0, stray}, 32'd0);
      run_op(mk(1'b0, 3'b010, 2'b00, 32'h180, 32'h0, 32'h5A5A0F0F, 0, 1, 1'b0, 4'b1111,
                32'h0, 32'h5A5A0F0F, 3), "post_rst_lw");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
